pipelined_datapath: RTL and testbench
=====================================

# pipelined_datapath

Three-stage pipelined successor to the single-cycle datapath: decode/register-read, execute, memory/writeback. Parametrised in data width, register count and data-memory depth. Adds valid-qualified issue, full forwarding so back-to-back dependent instructions need no stalls, and a retire port for the testbench and trace. Control signals still come from the external decoder, issued alongside each instruction.

## Interface
Parameters:
- WIDTH, 32, datapath and register width (≥8).
- REGS, 32, architectural registers (power of 2, 2..32); register index = low clog2(REGS) bits of the 5-bit instruction field.
- MEM_WORDS, 256, data-memory depth in WIDTH-bit words (power of 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ins_valid  in  1  ins and control inputs are a real instruction this cycle; low inserts a bubble.
- ins  in  32  instruction; rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
- MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite  in  1 each  control for ins, sampled with it.
- ALUOp  in  4  ALU function; 4'b0000 AND, 4'b0001 OR, 4'b0010 ADD, 4'b0110 SUB, 4'b0111 SLT.
- zero  out  1  ALU result == 0 for the instruction in EX.
- zero_valid  out  1  EX holds a valid instruction with Branch=1.
- wb_valid  out  1  an instruction retires this cycle.
- wb_reg  out  5  destination index of retiring instruction (0 if RegWrite=0).
- wb_data  out  WIDTH  value written (ALU result or load data).
- ovf_trap  out  1  present only with DATAPATH_OVF_TRAP_EN.

## Operation
- ID (cycle n): decode rs/rt, read register file, sign-extend imm to WIDTH, select destination (RegDst=0 → rd, 1 → rt). Capture into ID/EX on edge with valid=ins_valid.
- EX (n+1): operand B = ALUSrc ? imm : rt_value. ALU computes result, zero and signed overflow. zero/zero_valid are combinational from EX. Capture into EX/MW.
- MW (n+2): address = ALU_result[clog2(MEM_WORDS)+1:2] (byte offset ignored, upper bits ignored, wrap-around). MemWrite writes rt_value on the edge. Load data is read combinationally. Writeback = MemtoReg ? load : ALU result. The register file is written on the edge ending MW when valid & RegWrite.
- Register 0 always reads 0. Writes to it are discarded, and no value is forwarded from it.
- Forwarding into EX operands comes from MW: if MW is valid & RegWrite, its dest ≠ 0 and it equals the EX source, use the MW writeback value (load data included). No load-use stall.
- ID read bypass: if MW writes the register ID reads in the same cycle, ID captures the write value.
- Priority is MW forward over the registered operand. The forwarded rt also feeds store data.
- Invalid (bubble) slots never write registers or memory, never forward, and keep wb_valid/zero_valid low.
- Arithmetic wraps modulo 2^WIDTH. Overflow is ignored unless trap is enabled.

## Timing
- Latency: instruction issued at edge n retires (wb_valid high) during cycle n+2. Throughput is 1 per cycle.
- Reset (async assert, sync release): all pipeline valids cleared and all registers cleared to 0. zero=1 (EX operands 0), zero_valid=0, wb_valid=0, wb_reg=0, wb_data=0, ovf_trap=0. Data memory is not reset.
- Reset mid-operation: in-flight instructions are dropped. A store in MW at assertion does not occur.
- Simultaneous MemWrite and load to the same word in consecutive instructions: the load in the next cycle sees the new data.

## Configuration
- DATAPATH_OVF_TRAP_EN defined:
  - An ALU overflow on ADD/SUB in EX suppresses that instruction's register write and memory write.
  - ovf_trap is a one-cycle pulse in the instruction's MW cycle.
  - wb_valid still pulses, with wb_reg=0.
  - The suppressed result is not forwarded.
- Undefined: no ovf_trap port, and overflowing results write back wrapped.

## Test plan
- Reset then idle 5 cycles → wb_valid=0, zero_valid=0, all reg reads 0.
- ADDI-style r1=r0+5 then back-to-back r2=r1+r1 (ALUOp 0010, ALUSrc 0) → r2 retires 10 two cycles after issue, no bubbles.
- Store r2 at address 0x8, then immediate load r3 from 0x8, then r4=r3+r1 → r3=10, r4=15.
- SUB r1,r1 with Branch=1 → zero=1, zero_valid=1 in EX cycle. With r1≠r2 → zero=0.
- Write to r0 then read r0 → 0, and no forwarding of the written value.
- With DATAPATH_OVF_TRAP_EN, WIDTH=32: 0x7FFFFFFF+1 into r5 → ovf_trap pulse, r5 unchanged, dependent next instruction sees old r5.

Source files
------------

// File: rtl/pipelined_datapath.sv
// rtl/pipelined_datapath.sv - three-stage ID/EX/MW datapath with MW forwarding and a retire port
// Optional ALU overflow trap on ADD/SUB: define DATAPATH_OVF_TRAP_EN
module pipelined_datapath #(
  parameter int WIDTH     = 32,
  parameter int REGS      = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ins_valid,
  input  logic [31:0]      ins,
  input  logic             MemtoReg,
  input  logic             MemWrite,
  input  logic             Branch,
  input  logic             ALUSrc,
  input  logic             RegDst,
  input  logic             RegWrite,
  input  logic [3:0]       ALUOp,
  output logic             zero,
  output logic             zero_valid,
  output logic             wb_valid,
  output logic [4:0]       wb_reg,
  output logic [WIDTH-1:0] wb_data
`ifdef DATAPATH_OVF_TRAP_EN
  ,
  output logic             ovf_trap
`endif
);
  localparam int RW = $clog2(REGS);
  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  logic [WIDTH-1:0] rf_q  [REGS];
  logic [WIDTH-1:0] mem_q [MEM_WORDS];

  logic             ex_valid_q, ex_m2r_q, ex_mw_q, ex_br_q, ex_src_q, ex_rw_q;
  logic [3:0]       ex_op_q;
  logic [RW-1:0]    ex_rs_q, ex_rt_q, ex_dest_q;
  logic [WIDTH-1:0] ex_a_q, ex_b_q, ex_imm_q;

  logic             mw_valid_q, mw_m2r_q, mw_mw_q, mw_rw_q;
  logic             mw_rw_d, mw_mw_d;
  logic [RW-1:0]    mw_dest_q;
  logic [WIDTH-1:0] mw_res_q, mw_st_q;

  // MW: memory access, writeback select and the forwarding source
  logic [AW-1:0]    mw_addr;
  logic [WIDTH-1:0] wb_val;
  logic             mw_we;

  assign mw_addr  = mw_res_q[AW+1:2];
  assign wb_val   = mw_m2r_q ? mem_q[mw_addr] : mw_res_q;
  assign mw_we    = mw_valid_q & mw_rw_q & (mw_dest_q != '0);
  assign wb_valid = mw_valid_q;
  assign wb_reg   = (mw_valid_q & mw_rw_q) ? 5'(mw_dest_q) : 5'd0;
  assign wb_data  = mw_valid_q ? wb_val : '0;

  logic [RW-1:0]    id_rs, id_rt, id_dest;
  logic [WIDTH-1:0] id_a, id_b, id_imm;
  logic             unused_ins;

  assign id_rs      = ins[21 +: RW];
  assign id_rt      = ins[16 +: RW];
  assign id_dest    = RegDst ? id_rt : ins[11 +: RW];
  assign id_imm     = WIDTH'($signed(ins[15:0]));
  assign id_a       = (mw_we && mw_dest_q == id_rs) ? wb_val : rf_q[id_rs];
  assign id_b       = (mw_we && mw_dest_q == id_rt) ? wb_val : rf_q[id_rt];
  assign unused_ins = ^ins;

  logic [WIDTH-1:0] ex_a, ex_b, ex_opb, alu_res;
  logic             alu_ovf, ex_trap;

  assign ex_a   = (mw_we && mw_dest_q == ex_rs_q) ? wb_val : ex_a_q;
  assign ex_b   = (mw_we && mw_dest_q == ex_rt_q) ? wb_val : ex_b_q;
  assign ex_opb = ex_src_q ? ex_imm_q : ex_b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ex_op_q)
      OP_AND: alu_res = ex_a & ex_opb;
      OP_OR:  alu_res = ex_a | ex_opb;
      OP_ADD: begin
        alu_res = ex_a + ex_opb;
        alu_ovf = (ex_a[WIDTH-1] == ex_opb[WIDTH-1]) && (alu_res[WIDTH-1] != ex_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = ex_a - ex_opb;
        alu_ovf = (ex_a[WIDTH-1] != ex_opb[WIDTH-1]) && (alu_res[WIDTH-1] != ex_a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(ex_a) < $signed(ex_opb))};
      default: alu_res = '0;
    endcase
  end

  assign zero       = (alu_res == '0);
  assign zero_valid = ex_valid_q & ex_br_q;

`ifdef DATAPATH_OVF_TRAP_EN
  logic mw_ovf_q;
  assign ex_trap  = ex_valid_q & alu_ovf;
  assign ovf_trap = mw_valid_q & mw_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mw_ovf_q <= 1'b0;
    else        mw_ovf_q <= ex_trap;
  end
`else
  logic unused_ovf;
  assign ex_trap    = 1'b0;
  assign unused_ovf = alu_ovf;
`endif

  // A trapped instruction still retires but loses its register and memory side effects
  assign mw_rw_d = ex_rw_q & ~ex_trap;
  assign mw_mw_d = ex_mw_q & ~ex_trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_m2r_q   <= 1'b0;
      ex_mw_q    <= 1'b0;
      ex_br_q    <= 1'b0;
      ex_src_q   <= 1'b0;
      ex_rw_q    <= 1'b0;
      ex_op_q    <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_dest_q  <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      mw_valid_q <= 1'b0;
      mw_m2r_q   <= 1'b0;
      mw_mw_q    <= 1'b0;
      mw_rw_q    <= 1'b0;
      mw_dest_q  <= '0;
      mw_res_q   <= '0;
      mw_st_q    <= '0;
      for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
    end else begin
      ex_valid_q <= ins_valid;
      ex_m2r_q   <= MemtoReg;
      ex_mw_q    <= MemWrite;
      ex_br_q    <= Branch;
      ex_src_q   <= ALUSrc;
      ex_rw_q    <= RegWrite;
      ex_op_q    <= ALUOp;
      ex_rs_q    <= id_rs;
      ex_rt_q    <= id_rt;
      ex_dest_q  <= id_dest;
      ex_a_q     <= id_a;
      ex_b_q     <= id_b;
      ex_imm_q   <= id_imm;
      mw_valid_q <= ex_valid_q;
      mw_m2r_q   <= ex_m2r_q;
      mw_mw_q    <= mw_mw_d;
      mw_rw_q    <= mw_rw_d;
      mw_dest_q  <= ex_dest_q;
      mw_res_q   <= alu_res;
      mw_st_q    <= ex_b;
      if (mw_we) rf_q[mw_dest_q] <= wb_val;
    end
  end

  always_ff @(posedge clk) begin
    if (mw_valid_q && mw_mw_q) mem_q[mw_addr] <= mw_st_q;
  end

endmodule

// File: tb/tb_pipelined_datapath.sv
// tb/tb_pipelined_datapath.sv - sequential-ISA reference model bench for pipelined_datapath
// Honours DATAPATH_OVF_TRAP_EN when defined for both DUT and bench
module tb_pipelined_datapath;
  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD_ = 4'b0010, SUB_ = 4'b0110, SLT_ = 4'b0111;
  localparam longint MAXP = 64'sd2147483647;
  localparam longint MINN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ins_valid;
  logic [31:0] ins;
  logic        MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite;
  logic [3:0]  ALUOp;
  logic        zero, zero_valid, wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
`ifdef DATAPATH_OVF_TRAP_EN
  logic        ovf_trap;
`endif

  always #5 clk = ~clk;

  pipelined_datapath #(.WIDTH(32), .REGS(32), .MEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins(ins),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .Branch(Branch), .ALUSrc(ALUSrc),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUOp(ALUOp),
    .zero(zero), .zero_valid(zero_valid), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .wb_data(wb_data)
`ifdef DATAPATH_OVF_TRAP_EN
    , .ovf_trap(ovf_trap)
`endif
  );

  typedef struct {
    logic        vld;
    logic        br;
    logic        zr;
    logic [4:0]  rg;
    logic [31:0] dat;
    logic        trap;
    logic        cchk;
    logic [31:0] cval;
  } exp_t;

  logic [31:0] R [32];
  logic [31:0] M [256];
  exp_t ex_e, mw_e;
  int nchk = 0;
  int nerr = 0;

  function automatic exp_t bubble_e();
    exp_t e;
    e.vld = 1'b0; e.br = 1'b0; e.zr = 1'b0; e.rg = '0; e.dat = '0;
    e.trap = 1'b0; e.cchk = 1'b0; e.cval = '0;
    return e;
  endfunction

  // Architectural (one instruction at a time) semantics; the pipeline must be indistinguishable
  function automatic exp_t model(input logic [31:0] i, input logic [3:0] op,
                                 input logic src, dst, rw, mw, m2r, br);
    exp_t e;
    logic [4:0] rs, rt, dest;
    logic [31:0] a, b, opb, res, wd;
    longint sa, sb, sr;
    logic ovf, trapped;
    rs = i[25:21]; rt = i[20:16];
    dest = dst ? rt : i[15:11];
    a = R[rs]; b = R[rt];
    opb = src ? {{16{i[15]}}, i[15:0]} : b;
    sa = longint'($signed(a)); sb = longint'($signed(opb));
    ovf = 1'b0; res = '0; sr = 0;
    case (op)
      AND_: res = a & opb;
      OR_:  res = a | opb;
      ADD_: begin sr = sa + sb; res = sr[31:0]; ovf = (sr > MAXP) || (sr < MINN); end
      SUB_: begin sr = sa - sb; res = sr[31:0]; ovf = (sr > MAXP) || (sr < MINN); end
      SLT_: res = (sa < sb) ? 32'd1 : 32'd0;
      default: res = '0;
    endcase
`ifdef DATAPATH_OVF_TRAP_EN
    trapped = ovf;
`else
    trapped = 1'b0;
`endif
    wd = m2r ? M[res[9:2]] : res;
    if (!trapped) begin
      if (mw) M[res[9:2]] = b;
      if (rw && dest != 0) R[dest] = wd;
    end
    e = bubble_e();
    e.vld = 1'b1; e.br = br; e.zr = (res == 0);
    e.rg = (rw && !trapped) ? dest : 5'd0;
    e.dat = wd; e.trap = trapped;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nchk++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs();
    chk("wb_valid", wb_valid, mw_e.vld);
    if (mw_e.vld) begin
      chk("wb_reg", wb_reg, mw_e.rg);
      if (!mw_e.trap) chk("wb_data", wb_data, mw_e.dat);
      if (mw_e.cchk) chk("wb_data_const", wb_data, mw_e.cval);
    end
    chk("zero_valid", zero_valid, ex_e.vld & ex_e.br);
    if (ex_e.vld) chk("zero", zero, ex_e.zr);
`ifdef DATAPATH_OVF_TRAP_EN
    chk("ovf_trap", ovf_trap, mw_e.vld & mw_e.trap);
`endif
  endtask

  task automatic step(input logic v, input logic [31:0] i, input logic [3:0] op,
                      input logic src, dst, rw, mw, m2r, br, input logic apply,
                      input logic cchk, input logic [31:0] cval);
    exp_t e;
    @(negedge clk);
    check_outputs();
    mw_e = ex_e;
    ins_valid = v; ins = i; ALUOp = op; ALUSrc = src; RegDst = dst;
    RegWrite = rw; MemWrite = mw; MemtoReg = m2r; Branch = br;
    e = (v && apply) ? model(i, op, src, dst, rw, mw, m2r, br) : bubble_e();
    e.cchk = cchk; e.cval = cval;
    ex_e = e;
  endtask

  task automatic bub();
    step(1'b0, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
         1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, '0);
  endtask

  task automatic alu(input logic [3:0] op, input logic [4:0] rs, rt, rd, input logic rw, br,
                     input logic cchk, input logic [31:0] cval);
    step(1'b1, {6'd0, rs, rt, rd, 11'd0}, op, 1'b0, 1'b0, rw, 1'b0, 1'b0, br, 1'b1, cchk, cval);
  endtask

  task automatic alui(input logic [3:0] op, input logic [4:0] rs, rt, input logic [15:0] imm,
                      input logic cchk, input logic [31:0] cval);
    step(1'b1, {6'd0, rs, rt, imm}, op, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cchk, cval);
  endtask

  task automatic ld(input logic [4:0] rt, input logic [15:0] addr, input logic cchk,
                    input logic [31:0] cval);
    step(1'b1, {6'd0, 5'd0, rt, addr}, ADD_, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, cchk, cval);
  endtask

  task automatic st(input logic [4:0] rt, input logic [15:0] addr);
    step(1'b1, {6'd0, 5'd0, rt, addr}, ADD_, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_zero_valid", zero_valid, 1'b0);
    chk("rst_wb_reg", wb_reg, 5'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_zero", zero, 1'b1);
`ifdef DATAPATH_OVF_TRAP_EN
    chk("rst_ovf_trap", ovf_trap, 1'b0);
`endif
  endtask

  initial begin
    logic [3:0] ops [5];
    ops[0] = AND_; ops[1] = OR_; ops[2] = ADD_; ops[3] = SUB_; ops[4] = SLT_;
    for (int r = 0; r < 32; r++) R[r] = '0;
    ex_e = bubble_e(); mw_e = bubble_e();
    ins_valid = 0; ins = '0; ALUOp = '0; ALUSrc = 0; RegDst = 0;
    RegWrite = 0; MemWrite = 0; MemtoReg = 0; Branch = 0;

    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    repeat (5) bub();

    for (int r = 1; r < 32; r++) alu(OR_, 5'(r), 5'(r), 5'd0, 1'b0, 1'b0, 1'b1, 32'd0);

    alui(ADD_, 5'd0, 5'd1, 16'd5, 1'b1, 32'd5);
    alu(ADD_, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 32'd10);
    st(5'd2, 16'h0008);
    ld(5'd3, 16'h0008, 1'b1, 32'd10);
    alu(ADD_, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b1, 32'd15);
    alu(SUB_, 5'd1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 32'd0);
    alu(SUB_, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, '0);
    alui(ADD_, 5'd0, 5'd0, 16'd77, 1'b0, '0);
    alu(ADD_, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 32'd0);
    bub();
    alu(OR_, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 32'd0);

    // r10 = 2^31-1 built without overflow, then r5 = r10 + 1 overflows
    alui(ADD_, 5'd0, 5'd5, 16'd123, 1'b1, 32'd123);
    alui(ADD_, 5'd0, 5'd10, 16'd1, 1'b0, '0);
    for (int k = 0; k < 30; k++) begin
      alu(ADD_, 5'd10, 5'd10, 5'd10, 1'b1, 1'b0, 1'b0, '0);
      alui(ADD_, 5'd10, 5'd10, 16'd1, 1'b0, '0);
    end
    alu(OR_, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF);
    alui(ADD_, 5'd10, 5'd5, 16'd1, 1'b0, '0);
`ifdef DATAPATH_OVF_TRAP_EN
    alu(ADD_, 5'd5, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1, 32'd123);
`else
    alu(ADD_, 5'd5, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1, 32'h8000_0000);
`endif
    bub(); bub();

    // Reset with a store sitting in MW: the store must be dropped, memory kept
    alui(ADD_, 5'd0, 5'd1, 16'h1234, 1'b0, '0);
    st(5'd1, 16'd80);
    alui(ADD_, 5'd0, 5'd1, 16'h0777, 1'b0, '0);
    bub(); bub();
    step(1'b1, {6'd0, 5'd0, 5'd1, 16'd80}, ADD_, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    bub();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    ex_e = bubble_e(); mw_e = bubble_e();
    for (int r = 0; r < 32; r++) R[r] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ld(5'd3, 16'd80, 1'b1, 32'h0000_1234);
    alu(OR_, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0);

    for (int r = 1; r < 8; r++) alui(ADD_, 5'd0, 5'(r), 16'($urandom), 1'b0, '0);
    for (int w = 0; w < 16; w++) st(5'(1 + w % 7), 16'(w * 4));

    for (int n = 0; n < 500; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) bub();
      else if (kind == 1) ld(5'($urandom_range(0, 7)), 16'($urandom_range(0, 15) * 4), 1'b0, '0);
      else if (kind == 2) st(5'($urandom_range(0, 7)), 16'($urandom_range(0, 15) * 4));
      else
        step(1'b1, {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 11'($urandom)},
             ops[$urandom_range(0, 4)], 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) != 0), 1'b0, 1'b0, 1'($urandom), 1'b1, 1'b0, '0);
    end
    repeat (3) bub();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
